// File: rtl/mw_pkg.sv
// Shared types and constants for the microwave front-panel controller.
package mw_pkg;

  localparam int unsigned SEC_PER_MIN = 60;
  localparam int unsigned TIME_W      = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COOK   = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/microwave_controller_if.sv
// Controller <-> 1 Hz countdown timer link: setpoint, load/start, end indication.
interface microwave_controller_if;
  import mw_pkg::*;

  logic [TIME_W-1:0] set_min;
  logic [TIME_W-1:0] set_sec;
  logic              timer_load;
  logic              timer_start;
  logic              timer_end;

  modport master (output set_min, set_sec, timer_load, timer_start, input timer_end);
  modport slave  (input set_min, set_sec, timer_load, timer_start, output timer_end);

endinterface

// File: rtl/microwave_controller_time_entry.sv
// Cook-time setpoint register with saturating inc/dec and clear.
module time_entry
  import mw_pkg::*;
#(
  parameter int unsigned STEP_SEC = 10,
  parameter int unsigned MAX_MIN  = 59
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  input  logic              clr,
  output logic [TIME_W-1:0] mins,
  output logic [TIME_W-1:0] secs
);

  localparam int unsigned SW = TIME_W + 1;

  logic [SW-1:0]     sec_sum;
  logic [TIME_W-1:0] inc_min, inc_sec, dec_min, dec_sec;

  always_comb begin
    sec_sum = SW'(secs) + SW'(STEP_SEC);
    inc_min = mins;
    inc_sec = TIME_W'(sec_sum);
    if (sec_sum >= SW'(SEC_PER_MIN)) begin
      if (mins == TIME_W'(MAX_MIN)) begin
        inc_min = TIME_W'(MAX_MIN);
        inc_sec = TIME_W'(SEC_PER_MIN - 1);
      end else begin
        inc_min = mins + 1'b1;
        inc_sec = TIME_W'(sec_sum - SW'(SEC_PER_MIN));
      end
    end

    dec_min = mins;
    dec_sec = secs - TIME_W'(STEP_SEC);
    if (secs < TIME_W'(STEP_SEC)) begin
      if (mins != '0) begin
        dec_min = mins - 1'b1;
        dec_sec = secs + TIME_W'(SEC_PER_MIN - STEP_SEC);
      end else begin
        dec_min = '0;
        dec_sec = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mins <= '0;
      secs <= '0;
    end else if (clr) begin
      mins <= '0;
      secs <= '0;
    end else if (inc && !dec) begin
      mins <= inc_min;
      secs <= inc_sec;
    end else if (dec && !inc) begin
      mins <= dec_min;
      secs <= dec_sec;
    end
  end

endmodule

// File: rtl/microwave_controller.sv
// Front-panel FSM: button edges -> setpoint, timer load/start, door gating, done beep.
module microwave_controller
  import mw_pkg::*;
#(
  parameter int unsigned STEP_SEC = 10,
  parameter int unsigned BEEP_SEC = 3,
  parameter int unsigned MAX_MIN  = 59
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick_1hz,
  input  logic                          btn_inc,
  input  logic                          btn_dec,
  input  logic                          btn_start,
  input  logic                          btn_cancel,
  input  logic                          door_open,
  microwave_controller_if.master        tmr,
  output logic                          magnetron_on,
  output logic                          lamp_on,
  output logic                          beep,
  output logic [1:0]                    state_dbg
);

  localparam int unsigned BW = ($clog2(BEEP_SEC + 1) < 2) ? 2 : $clog2(BEEP_SEC + 1);

  // Bit order {cancel, start, dec, inc}
  logic [3:0] btn_q, btn_qq, btn_e;
  logic       door_q, door_rise;
  logic       te_s1, te_s2, te_s3, te_e;

  state_t        state, state_n;
  logic [BW-1:0] beep_cnt, cnt_n;
  logic          sp_inc, sp_dec, sp_clr, sp_zero;
  logic          load_n, start_n, mag_n, lamp_n, beep_n;

  assign btn_e     = btn_q & ~btn_qq;
  assign door_rise = door_open & ~door_q;
  assign te_e      = te_s2 & ~te_s3;
  assign sp_zero   = (tmr.set_min == '0) && (tmr.set_sec == '0);
  assign state_dbg = state;

  time_entry #(.STEP_SEC(STEP_SEC), .MAX_MIN(MAX_MIN)) u_time_entry (
    .clk  (clk),
    .rst  (rst),
    .inc  (sp_inc),
    .dec  (sp_dec),
    .clr  (sp_clr),
    .mins (tmr.set_min),
    .secs (tmr.set_sec)
  );

  always_comb begin
    state_n = state;
    cnt_n   = beep_cnt;
    sp_inc  = 1'b0;
    sp_dec  = 1'b0;
    sp_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (btn_e[3]) begin
          sp_clr = 1'b1;
        end else if (btn_e[2] && !door_open && !sp_zero) begin
          state_n = COOK;
        end else begin
          sp_inc = btn_e[0];
          sp_dec = btn_e[1];
        end
      end
      COOK: begin
        if (btn_e[3] || door_open) begin
          state_n = PAUSED;
        end else if (te_e) begin
          state_n = DONE;
          cnt_n   = '0;
        end
      end
      PAUSED: begin
        if (btn_e[3]) begin
          state_n = IDLE;
          sp_clr  = 1'b1;
        end else if (btn_e[2] && !door_open) begin
          state_n = COOK;
        end
      end
      DONE: begin
        if ((|btn_e) || door_rise) begin
          state_n = IDLE;
          sp_clr  = 1'b1;
        end else if (tick_1hz) begin
          cnt_n = beep_cnt + 1'b1;
          if (cnt_n == BW'(BEEP_SEC)) begin
            state_n = IDLE;
            sp_clr  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are computed from the next state so they register alongside it
    load_n  = (state_n == IDLE);
    start_n = (state_n == COOK);
    mag_n   = (state_n == COOK);
    beep_n  = (state_n == DONE);
    lamp_n  = (state_n == IDLE || state_n == DONE) ? door_open : 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q           <= '0;
      btn_qq          <= '0;
      door_q          <= 1'b0;
      te_s1           <= 1'b0;
      te_s2           <= 1'b0;
      te_s3           <= 1'b0;
      state           <= IDLE;
      beep_cnt        <= '0;
      tmr.timer_load  <= 1'b1;
      tmr.timer_start <= 1'b0;
      magnetron_on    <= 1'b0;
      lamp_on         <= 1'b0;
      beep            <= 1'b0;
    end else begin
      btn_q           <= {btn_cancel, btn_start, btn_dec, btn_inc};
      btn_qq          <= btn_q;
      door_q          <= door_open;
      te_s1           <= tmr.timer_end;
      te_s2           <= te_s1;
      te_s3           <= te_s2;
      state           <= state_n;
      beep_cnt        <= cnt_n;
      tmr.timer_load  <= load_n;
      tmr.timer_start <= start_n;
      magnetron_on    <= mag_n;
      lamp_on         <= lamp_n;
      beep            <= beep_n;
    end
  end

endmodule
